rx_config_sequencer: RTL and testbench
======================================

Name: rx_config_sequencer

Overview:
Owns the runtime tuning inputs of the central RX DSP core: the DDC, demix and DUC1-3 phase increments, and the DUC1-3 gains. A host writes shadow registers, then issues a commit. When any phase increment changes, the block ramps all DUC gains to zero, applies the new phase increments atomically, waits for the DSP pipeline to flush, then ramps the gains to their targets. This keeps phase-step and gain-step transients off the DAC outputs. The block sits between the control-register interface and rx_core, in the `clock` domain.

Parameters:
PHASE_W, 16, phase increment width
GAIN_W, 8, gain width
RAMP_DIV, 16, cycles between gain ramp steps (>=1)
GAIN_STEP, 4, maximum gain change per ramp step (>=1)
SETTLE_CYCLES, 64, post-apply flush wait (>=1)

Ports:
clock  in  1  DSP clock (same clock that drives the DDC/DUC)
reset  in  1  asynchronous, active-high reset
cfg_valid  in  1  shadow write request
cfg_ready  out  1  shadow write accepted when high together with cfg_valid
cfg_addr  in  3  0=ddc, 1=demix, 2/3/4=duc1/2/3 phase; 5/6/7=gain duc1/2/3
cfg_data  in  PHASE_W  write data; gains use [GAIN_W-1:0]
commit  in  1  single-cycle request to apply the shadows
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when a sequence completes
ddc_phase_inc, demix_phase_inc, duc1_phase_inc, duc2_phase_inc, duc3_phase_inc  out  PHASE_W each  live values sent to the core
gain_duc1, gain_duc2, gain_duc3  out  GAIN_W each  live values sent to the core

Behaviour:
- Reset (async assert; deassert is synchronous to `clock` upstream):
  - all shadows, live phases and gains = 0
  - state = IDLE, busy = 0, done = 0, cfg_ready = 1
  - ramp and settle counters = 0
  - a reset mid-sequence aborts the sequence and applies these values immediately.
- cfg_ready = (state == IDLE). A write handshakes when cfg_valid & cfg_ready and updates the shadow on the next edge. Writes to gain shadows take cfg_data[GAIN_W-1:0].
- commit is sampled only in IDLE and is ignored in every other state, with no queueing.
- commit and a write in the same cycle: the write is included in that commit.
- phase_changed = any phase shadow differs from its live phase, evaluated on the committed (post-write) shadow values.
- States:
  - IDLE: on commit, go to RAMP_DOWN if phase_changed, else go to RAMP_UP.
  - RAMP_DOWN: the ramp tick fires when div_cnt == RAMP_DIV-1; div_cnt wraps to 0 on the tick. On each tick, every gain = max(gain - GAIN_STEP, 0). Leave the state when all three gains are 0, checked every cycle; entering with all gains already 0 exits after 1 cycle.
  - APPLY: one cycle; all five live phases load from their shadows simultaneously; settle counter cleared.
  - SETTLE: hold for SETTLE_CYCLES cycles, with gains held at 0, then go to RAMP_UP.
  - RAMP_UP (moves toward target, up or down): on each tick, each gain moves toward its shadow by min(GAIN_STEP, |shadow - gain|). When all three gains equal their shadows, go to IDLE and pulse done for 1 cycle. Entering with the gains already equal gives done 1 cycle after entry.
- div_cnt resets to 0 on every state entry, so the first step lands RAMP_DIV cycles after entry.
- Gain arithmetic is unsigned with no wrap; saturation is enforced by the min/max above.
- The live phase outputs never change outside APPLY.
- busy = (state != IDLE), registered from state.
- Sequence length from commit with a phase change: 1 + RAMP_DIV * ceil(maxgain / GAIN_STEP) + 1 + SETTLE_CYCLES + RAMP_DIV * ceil(maxtarget / GAIN_STEP) + done, ±1 cycle for the state-exit registration. The bench uses the exact formula from the RTL and must match it cycle for cycle.

Decomposition:
- Package rx_cfg_pkg:
  - state_t enum {IDLE, RAMP_DOWN, APPLY, SETTLE, RAMP_UP}
  - cfg address localparams ADDR_DDC .. ADDR_GAIN3
  - a function gain_step_toward(cur, tgt, step)
- One sub-module, rx_gain_ramp: a single gain register with tick, target, mode (down-to-zero or toward target) and an at_target flag. Instantiated three times.

Test Plan:
- Reset, then write gain1 = 20 and commit with no phase change (GAIN_STEP=4, RAMP_DIV=16). Required: goes straight to RAMP_UP; gain_duc1 = 4, 8, ... 20 at 16-cycle intervals; done pulses once; phases stay 0.
- With gains 20/8/0 live, write ddc = 0x1234 and commit. Required: gains ramp to 0 (gain1 reaches 0 after 5 ticks); ddc_phase_inc = 0x1234 exactly one cycle after all gains are 0; gains stay 0 for 64 cycles; then they return to 20/8/0.
- Write duc2 = 0x0400 with commit in the same cycle. Required: duc2_phase_inc = 0x0400 after the sequence; no other phase changes.
- Pulse commit and cfg_valid during SETTLE. Required: cfg_ready = 0, no shadow change, no second sequence, exactly one done.
- Target gain1 = 6 from a live value of 20. Required: steps 16, 12, 8, 6 (last step clipped to 2); no undershoot.
- Assert reset in the middle of RAMP_DOWN. Required: all outputs 0 and busy = 0 asynchronously. After release, a commit with all shadows 0 gives done with no output change.

Source files
------------

// File: rtl/rx_cfg_pkg.sv
// rx_cfg_pkg: shared types and helpers for the RX configuration sequencer.
//   state_t           sequencer states
//   ADDR_*            shadow register addresses on cfg_addr
//   gain_step_toward  moves a value toward a goal by at most one step, no overshoot
package rx_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_DOWN,
        APPLY,
        SETTLE,
        RAMP_UP
    } state_t;

    localparam logic [2:0] ADDR_DDC   = 3'd0;
    localparam logic [2:0] ADDR_DEMIX = 3'd1;
    localparam logic [2:0] ADDR_DUC1  = 3'd2;
    localparam logic [2:0] ADDR_DUC2  = 3'd3;
    localparam logic [2:0] ADDR_DUC3  = 3'd4;
    localparam logic [2:0] ADDR_GAIN1 = 3'd5;
    localparam logic [2:0] ADDR_GAIN2 = 3'd6;
    localparam logic [2:0] ADDR_GAIN3 = 3'd7;

    localparam int unsigned NUM_PHASES = 5;
    localparam int unsigned NUM_GAINS  = 3;

    // Operands are zero-extended to 32 bits by the caller, so neither the
    // subtraction nor the addition can wrap for gain widths below 32.
    function automatic logic [31:0] gain_step_toward(
        input logic [31:0] cur,
        input logic [31:0] tgt,
        input logic [31:0] step
    );
        logic [31:0] result;
        if (cur > tgt)
            result = ((cur - tgt) > step) ? (cur - step) : tgt;
        else
            result = ((tgt - cur) > step) ? (cur + step) : tgt;
        return result;
    endfunction

endpackage

// File: rtl/rx_config_sequencer_gain_ramp.sv
// rx_gain_ramp: one live gain register that steps on each tick.
//   clock, reset  DSP clock, asynchronous active-high reset (gain -> 0)
//   tick          advance one ramp step this cycle
//   mode          0 = ramp toward zero, 1 = ramp toward target
//   target        shadow gain used when mode = 1
//   gain          live gain
//   at_target     gain equals the current goal (zero or target)
module rx_gain_ramp
    import rx_cfg_pkg::*;
#(
    parameter int unsigned GAIN_W    = 8,
    parameter int unsigned GAIN_STEP = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              mode,
    input  logic [GAIN_W-1:0] target,
    output logic [GAIN_W-1:0] gain,
    output logic              at_target
);

    logic [GAIN_W-1:0] goal;

    assign goal      = mode ? target : '0;
    assign at_target = (gain == goal);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            gain <= '0;
        else if (tick)
            gain <= GAIN_W'(gain_step_toward(32'(gain), 32'(goal), 32'(GAIN_STEP)));
    end

endmodule

// File: rtl/rx_config_sequencer.sv
// rx_config_sequencer: shadows the RX DSP tuning registers and applies them
// glitch-free. A phase change ramps all DUC gains to zero, loads all five
// phase increments at once, waits for the pipeline to flush, then ramps the
// gains back to their shadow targets. Without a phase change only the gain
// ramp runs.
//   clock, reset         DSP clock, asynchronous active-high reset
//   cfg_valid/cfg_ready  shadow write handshake (ready only in IDLE)
//   cfg_addr, cfg_data   0..4 phase shadows, 5..7 gain shadows (low GAIN_W bits)
//   commit               apply request, sampled only in IDLE
//   busy                 sequence in progress
//   done                 one-cycle pulse at sequence completion
//   *_phase_inc          live phase increments to the core
//   gain_duc1..3         live gains to the core
module rx_config_sequencer
    import rx_cfg_pkg::*;
#(
    parameter int unsigned PHASE_W       = 16,
    parameter int unsigned GAIN_W        = 8,
    parameter int unsigned RAMP_DIV      = 16,
    parameter int unsigned GAIN_STEP     = 4,
    parameter int unsigned SETTLE_CYCLES = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_addr,
    input  logic [PHASE_W-1:0] cfg_data,
    input  logic               commit,
    output logic               busy,
    output logic               done,
    output logic [PHASE_W-1:0] ddc_phase_inc,
    output logic [PHASE_W-1:0] demix_phase_inc,
    output logic [PHASE_W-1:0] duc1_phase_inc,
    output logic [PHASE_W-1:0] duc2_phase_inc,
    output logic [PHASE_W-1:0] duc3_phase_inc,
    output logic [GAIN_W-1:0]  gain_duc1,
    output logic [GAIN_W-1:0]  gain_duc2,
    output logic [GAIN_W-1:0]  gain_duc3
);

    localparam int unsigned DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(RAMP_DIV - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [DIV_W-1:0]      div_cnt;
    logic [SETTLE_W-1:0]   settle_cnt;

    logic [PHASE_W-1:0]    phase_shadow [NUM_PHASES];
    logic [PHASE_W-1:0]    phase_post   [NUM_PHASES];
    logic [PHASE_W-1:0]    phase_live   [NUM_PHASES];
    logic [GAIN_W-1:0]     gain_shadow  [NUM_GAINS];
    logic [GAIN_W-1:0]     gain_live    [NUM_GAINS];
    logic [NUM_GAINS-1:0]  at_target;

    logic                  wr_en;
    logic                  phase_changed;
    logic                  ramping;
    logic                  tick;
    logic                  all_at_target;

    assign wr_en         = cfg_valid & cfg_ready;
    assign ramping       = (state == RAMP_DOWN) || (state == RAMP_UP);
    assign tick          = ramping && (div_cnt == DIV_LAST);
    assign all_at_target = &at_target;

    // Shadow values as they will be after this cycle's write, so a write
    // issued together with commit takes part in the phase comparison.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PHASES; i++)
            phase_post[i] = (wr_en && (cfg_addr == 3'(ADDR_DDC + i))) ? cfg_data : phase_shadow[i];
        phase_changed = 1'b0;
        for (int unsigned i = 0; i < NUM_PHASES; i++)
            if (phase_post[i] != phase_live[i])
                phase_changed = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (commit) state_next = phase_changed ? RAMP_DOWN : RAMP_UP;
            RAMP_DOWN: if (all_at_target) state_next = APPLY;
            APPLY:     state_next = SETTLE;
            SETTLE:    if (settle_cnt == SETTLE_LAST) state_next = RAMP_UP;
            RAMP_UP:   if (all_at_target) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
            done       <= 1'b0;
            div_cnt    <= '0;
            settle_cnt <= '0;
            for (int unsigned i = 0; i < NUM_PHASES; i++) begin
                phase_shadow[i] <= '0;
                phase_live[i]   <= '0;
            end
            for (int unsigned i = 0; i < NUM_GAINS; i++)
                gain_shadow[i] <= '0;
        end else begin
            state     <= state_next;
            busy      <= (state_next != IDLE);
            cfg_ready <= (state_next == IDLE);
            done      <= (state == RAMP_UP) && (state_next == IDLE);

            // Divider restarts on every state entry and wraps on each tick.
            div_cnt    <= (ramping && (state_next == state) && !tick) ? div_cnt + 1'b1 : '0;
            settle_cnt <= ((state == SETTLE) && (state_next == SETTLE)) ? settle_cnt + 1'b1 : '0;

            if (wr_en) begin
                for (int unsigned i = 0; i < NUM_PHASES; i++)
                    if (cfg_addr == 3'(ADDR_DDC + i))
                        phase_shadow[i] <= cfg_data;
                for (int unsigned i = 0; i < NUM_GAINS; i++)
                    if (cfg_addr == 3'(ADDR_GAIN1 + i))
                        gain_shadow[i] <= cfg_data[GAIN_W-1:0];
            end

            // Live phases are registered on the edge entering APPLY so they
            // are visible for the whole APPLY cycle, one cycle after the
            // gains reach zero.
            if ((state == RAMP_DOWN) && (state_next == APPLY))
                for (int unsigned i = 0; i < NUM_PHASES; i++)
                    phase_live[i] <= phase_shadow[i];
        end
    end

    for (genvar g = 0; g < NUM_GAINS; g++) begin : g_ramp
        rx_gain_ramp #(
            .GAIN_W    (GAIN_W),
            .GAIN_STEP (GAIN_STEP)
        ) u_ramp (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .mode      (state == RAMP_UP),
            .target    (gain_shadow[g]),
            .gain      (gain_live[g]),
            .at_target (at_target[g])
        );
    end

    assign ddc_phase_inc   = phase_live[0];
    assign demix_phase_inc = phase_live[1];
    assign duc1_phase_inc  = phase_live[2];
    assign duc2_phase_inc  = phase_live[3];
    assign duc3_phase_inc  = phase_live[4];
    assign gain_duc1       = gain_live[0];
    assign gain_duc2       = gain_live[1];
    assign gain_duc3       = gain_live[2];

endmodule

// File: tb/tb_rx_config_sequencer.sv
// Self-checking bench for rx_config_sequencer: directed table, two
// hand-written corner sequences and randomized traffic, all compared cycle by
// cycle against a closed-form timeline model of a commit.
module tb_rx_config_sequencer;
    import rx_cfg_pkg::*;

    localparam int PW     = 16;
    localparam int GW     = 8;
    localparam int DIV    = 16;
    localparam int STEP   = 4;
    localparam int SETTLE = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [2:0]    cfg_addr;
    logic [PW-1:0] cfg_data;
    logic          commit;
    logic          busy;
    logic          done;
    logic [PW-1:0] ddc, demix, duc1, duc2, duc3;
    logic [GW-1:0] g1, g2, g3;

    rx_config_sequencer #(
        .PHASE_W       (PW),
        .GAIN_W        (GW),
        .RAMP_DIV      (DIV),
        .GAIN_STEP     (STEP),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .commit          (commit),
        .busy            (busy),
        .done            (done),
        .ddc_phase_inc   (ddc),
        .demix_phase_inc (demix),
        .duc1_phase_inc  (duc1),
        .duc2_phase_inc  (duc2),
        .duc3_phase_inc  (duc3),
        .gain_duc1       (g1),
        .gain_duc2       (g2),
        .gain_duc3       (g3)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: shadow and live register contents.
    int sh_p[5], live_p[5], sh_g[3], live_g[3];
    // Timeline of the commit in flight (t = cycles after the commit edge).
    bit c_pc;
    int c_g0[3], c_tg[3], c_t0, c_up, c_end;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        bit          same_cycle;
        int          exp_end;
        int          exp_g1, exp_g2, exp_g3;
        logic [15:0] exp_ddc, exp_demix, exp_duc2;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int t, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
        end
    endtask

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Value after k saturating steps from 'from' toward 'to'.
    function automatic int move(input int from, input int to, input int k);
        if (from < to) return (from + STEP * k < to) ? from + STEP * k : to;
        return (from - STEP * k > to) ? from - STEP * k : to;
    endfunction

    function automatic int exp_gain(input int i, input int t);
        if (!c_pc) return move(c_g0[i], c_tg[i], t / DIV);
        if (t < c_up) return move(c_g0[i], 0, t / DIV);
        return move(0, c_tg[i], (t - c_up) / DIV);
    endfunction

    function automatic logic [127:0] dut_vec();
        return 128'({g1, g2, g3, ddc, demix, duc1, duc2, duc3, busy, done, cfg_ready});
    endfunction

    function automatic logic [127:0] exp_vec(input int t);
        logic [GW-1:0] g[3];
        logic [PW-1:0] p[5];
        logic          b, d;
        for (int i = 0; i < 3; i++) g[i] = GW'(exp_gain(i, t));
        for (int i = 0; i < 5; i++) p[i] = PW'((c_pc && t > c_t0) ? sh_p[i] : live_p[i]);
        b = (t < c_end);
        d = (t == c_end);
        return 128'({g[0], g[1], g[2], p[0], p[1], p[2], p[3], p[4], b, d, ~b});
    endfunction

    task automatic model_write(input logic [2:0] a, input logic [PW-1:0] d);
        int ai;
        ai = int'(a);
        if (ai < 5) sh_p[ai] = int'(d);
        else sh_g[ai - 5] = int'(d[GW-1:0]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin sh_p[i] = 0; live_p[i] = 0; end
        for (int i = 0; i < 3; i++) begin sh_g[i] = 0; live_g[i] = 0; end
    endtask

    task automatic snapshot();
        int nd, nu;
        nd = 0; nu = 0;
        c_pc = 1'b0;
        for (int i = 0; i < 5; i++) if (sh_p[i] != live_p[i]) c_pc = 1'b1;
        for (int i = 0; i < 3; i++) begin c_g0[i] = live_g[i]; c_tg[i] = sh_g[i]; end
        if (c_pc) begin
            for (int i = 0; i < 3; i++) begin
                if (ceil_div(c_g0[i], STEP) > nd) nd = ceil_div(c_g0[i], STEP);
                if (ceil_div(c_tg[i], STEP) > nu) nu = ceil_div(c_tg[i], STEP);
            end
            c_t0  = DIV * nd;
            c_up  = c_t0 + 2 + SETTLE;
            c_end = c_up + DIV * nu + 1;
        end else begin
            for (int i = 0; i < 3; i++)
                if (ceil_div(abs_diff(c_g0[i], c_tg[i]), STEP) > nu)
                    nu = ceil_div(abs_diff(c_g0[i], c_tg[i]), STEP);
            c_t0  = 0;
            c_up  = 0;
            c_end = DIV * nu + 1;
        end
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0; commit = 1'b0; cfg_addr = 3'd0; cfg_data = '0;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [PW-1:0] d);
        @(negedge clock);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clock);
        idle_inputs();
        model_write(a, d);
    endtask

    // noise: 0 none, 1 random writes/commits while busy, 2 one write+commit in SETTLE
    task automatic run_commit(input bit with_write, input logic [2:0] a, input logic [PW-1:0] d,
                              input int noise, output int done_at, output int done_cnt);
        @(negedge clock);
        commit = 1'b1;
        if (with_write) begin
            cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
            model_write(a, d);
        end
        snapshot();
        done_at = -1; done_cnt = 0;
        for (int t = 0; t <= c_end + 1; t++) begin
            @(negedge clock);
            idle_inputs();
            check("seq", t, dut_vec(), exp_vec(t));
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if (noise == 1 && t < c_end && $urandom_range(0, 3) == 0) begin
                cfg_valid = 1'b1;
                cfg_addr  = 3'($urandom_range(0, 7));
                cfg_data  = 16'($urandom);
                commit    = 1'($urandom_range(0, 1));
            end
            if (noise == 2 && t == c_t0 + 10) begin
                cfg_valid = 1'b1; cfg_addr = ADDR_DDC; cfg_data = 16'h5555; commit = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) live_g[i] = sh_g[i];
        if (c_pc) for (int i = 0; i < 5; i++) live_p[i] = sh_p[i];
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int            done_at, done_cnt, nw;
        logic [2:0]    a;
        logic [PW-1:0] d;
        bit            same;

        //           addr        data      same end  g1 g2 g3 ddc      demix    duc2
        vecs[0] = '{ADDR_GAIN1, 16'd20,    1'b0, 81,  20, 0, 0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1] = '{ADDR_GAIN2, 16'd8,     1'b1, 33,  20, 8, 0, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{ADDR_DDC,   16'h1234,  1'b0, 227, 20, 8, 0, 16'h1234, 16'h0000, 16'h0000};
        vecs[3] = '{ADDR_DUC2,  16'h0400,  1'b1, 227, 20, 8, 0, 16'h1234, 16'h0000, 16'h0400};
        vecs[4] = '{ADDR_GAIN1, 16'd6,     1'b0, 65,  6,  8, 0, 16'h1234, 16'h0000, 16'h0400};
        vecs[5] = '{ADDR_GAIN3, 16'h0109,  1'b1, 49,  6,  8, 9, 16'h1234, 16'h0000, 16'h0400};
        vecs[6] = '{ADDR_GAIN2, 16'h7708,  1'b1, 1,   6,  8, 9, 16'h1234, 16'h0000, 16'h0400};
        vecs[7] = '{ADDR_DDC,   16'h1234,  1'b0, 1,   6,  8, 9, 16'h1234, 16'h0000, 16'h0400};
        vecs[8] = '{ADDR_DEMIX, 16'hFFFF,  1'b0, 163, 6,  8, 9, 16'h1234, 16'hFFFF, 16'h0400};

        model_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("in_reset", 0, dut_vec(), 128'd1);
        reset = 1'b0;
        @(negedge clock);
        check("reset_state", 0, dut_vec(), 128'd1);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            if (!vecs[v].same_cycle) write_reg(vecs[v].addr, vecs[v].data);
            run_commit(vecs[v].same_cycle, vecs[v].addr, vecs[v].data, 0, done_at, done_cnt);
            check("done_time", v, 128'(done_at), 128'(vecs[v].exp_end));
            check("done_once", v, 128'(done_cnt), 128'd1);
            check("final", v, 128'({g1, g2, g3, ddc, demix, duc2}),
                  128'({GW'(vecs[v].exp_g1), GW'(vecs[v].exp_g2), GW'(vecs[v].exp_g3),
                        vecs[v].exp_ddc, vecs[v].exp_demix, vecs[v].exp_duc2}));
        end

        // Write and commit during SETTLE must be ignored
        write_reg(ADDR_DDC, 16'h0001);
        run_commit(1'b0, 3'd0, '0, 2, done_at, done_cnt);
        check("settle_done_once", 0, 128'(done_cnt), 128'd1);
        check("settle_ddc", 0, 128'(ddc), 128'h0001);
        run_commit(1'b0, 3'd0, '0, 0, done_at, done_cnt);
        check("settle_no_shadow_change", 0, 128'(done_at), 128'd1);

        // Asynchronous reset in the middle of RAMP_DOWN
        write_reg(ADDR_DUC3, 16'h0777);
        @(negedge clock);
        commit = 1'b1;
        @(negedge clock);
        commit = 1'b0;
        repeat (20) @(negedge clock);
        check("busy_before_reset", 0, 128'({busy, g1 != 0}), 128'b11);
        #1 reset = 1'b1;
        #1 check("async_reset", 0, dut_vec(), 128'd1);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        run_commit(1'b0, 3'd0, '0, 0, done_at, done_cnt);
        check("post_reset_commit", 0, 128'({done_at[7:0], g1, g2, g3, ddc, duc3}), 128'({8'd1, 24'd0, 32'd0}));

        // Randomized traffic
        for (int it = 0; it < 10; it++) begin
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                a = 3'($urandom_range(0, 7));
                if (a >= ADDR_GAIN1) d = {8'($urandom), 8'($urandom_range(0, 40))};
                else d = ($urandom_range(0, 1) == 1) ? 16'(sh_p[int'(a)]) : 16'($urandom);
                write_reg(a, d);
            end
            same = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            if (a >= ADDR_GAIN1) d = {8'($urandom), 8'($urandom_range(0, 40))};
            else d = 16'($urandom);
            run_commit(same, a, d, 1, done_at, done_cnt);
            check("rand_done_once", it, 128'(done_cnt), 128'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
